video_stream_gen: RTL
=====================

# video_stream_gen

Synthesizable video-stream source that emits pixels on the team's `di/de/hs/vs` stream protocol, the same protocol `scaler_h` and the other scaler stages consume. It generates frames of run-time width and height with a programmable number of empty cycles per pixel and programmable line and frame blanking. It fills each frame with a selectable test pattern. It drives scalers and other stages on hardware where no camera or BMP-reading bench is available, and it also serves as a reusable stimulus source for benches.

## Interface

Parameters:
- `PIXEL_WIDTH`, 8: width of `do_o`.
- `LINE_SIZE_MAX`, 4096: maximum line width in pixels. Larger `width_i` values are clamped to this.
- `FRAME_SIZE_MAX`, 2048: maximum frame height in lines. Larger `height_i` values are clamped to this.
- `BLANK_WIDTH`, 16: width of the gap and blanking counters.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-low (0 = reset).
- `en_i`, input, 1: run. While high, frames are generated back-to-back.
- `width_i`, input, clog2(LINE_SIZE_MAX+1): pixels per line.
- `height_i`, input, clog2(FRAME_SIZE_MAX+1): lines per frame.
- `de_gap_i`, input, 4: number of `de=0` cycles before each pixel. 0 means contiguous pixels; 1 matches the existing `DE_I_PERIOD=2` bench stimulus.
- `hblank_i`, input, BLANK_WIDTH: line-blanking cycles.
- `vblank_i`, input, BLANK_WIDTH: frame-blanking cycles.
- `pattern_i`, input, 2: 0 = horizontal ramp, 1 = vertical ramp, 2 = delta pulse, 3 = checker.
- `pulse_x_i`, input, 16: x position of the delta pulse.
- `pulse_y_i`, input, 16: y position of the delta pulse.
- `do_o`, output, PIXEL_WIDTH: pixel data. Valid only when `de_o` is high.
- `de_o`, output, 1: pixel valid.
- `hs_o`, output, 1: high during line blanking and idle.
- `vs_o`, output, 1: high during frame blanking and idle.
- `busy_o`, output, 1: high while a frame is in progress.
- `frame_done_o`, output, 1: one-cycle pulse on the last cycle of frame blanking.

## Operation

- States: IDLE, GAP, PIX, HBLANK, VBLANK.
- IDLE: outputs are `hs=1`, `vs=1`, `de=0`.
  - If `en_i` is high, `width_i≠0` and `height_i≠0`, all configuration inputs are latched and the next state is GAP, or PIX when `de_gap=0`.
  - Configuration is latched only in IDLE and on the VBLANK→next-frame transition. Changes at any other time are ignored for the current frame.
- GAP: outputs `hs=0`, `vs=0`, `de=0` for `de_gap` cycles, then goes to PIX.
- PIX: one cycle with `de=1` and `do_o` = pattern(x, y), then x increments.
  - If x < W-1: next state is GAP, or PIX when `de_gap=0`.
  - If x = W-1 and y < H-1: next state is HBLANK.
  - If x = W-1 and y = H-1: next state is VBLANK.
- HBLANK: `hs=1`, `vs=0`, `de=0` for `max(hblank,1)` cycles. Then y increments, x is reset to 0, and the next state is GAP or PIX.
- VBLANK: `hs=1`, `vs=1`, `de=0` for `max(vblank,1)` cycles. `frame_done_o` pulses on the final cycle.
  - If `en_i` is high, configuration is re-latched and the next frame starts with y=0.
  - Otherwise the next state is IDLE.
- Dropping `en_i` mid-frame does not truncate the frame. The current frame always completes.
- Patterns:
  - Horizontal ramp: `do_o` = x[PIXEL_WIDTH-1:0].
  - Vertical ramp: `do_o` = y[PIXEL_WIDTH-1:0].
  - Delta pulse: all ones at (pulse_x, pulse_y), 0 elsewhere. A pulse position outside the frame produces an all-zero frame.
  - Checker: all ones when x[3] ^ y[3] is 1, else 0.
- `busy_o` is high from the first GAP/PIX cycle through the last VBLANK cycle.

## Timing

- All outputs are registered. Reset values: `do_o=0`, `de_o=0`, `hs_o=1`, `vs_o=1`, `busy_o=0`, `frame_done_o=0`.
- Start latency: if `en_i` is sampled high in IDLE at edge n, `hs_o` falls at edge n+1 and the first `de_o` occurs at edge n+1+de_gap.
- Each pixel occupies de_gap+1 cycles. `hs_o` stays low for W·(de_gap+1) cycles per line.
- Frame length is H·W·(de_gap+1) + (H-1)·max(hblank,1) + max(vblank,1) cycles.
- On the last line, `hs_o` and `vs_o` rise on the same edge.
- Reset asserted mid-frame: outputs return to their reset values on the next edge and the state returns to IDLE. No partial `frame_done_o` is generated.

## Structure

- Package `video_gen_pkg`: the state enum and the pattern encoding constants (`PAT_HRAMP`, `PAT_VRAMP`, `PAT_DELTA`, `PAT_CHECK`).
- Sub-module `video_pattern_gen`: combinational pixel value from x, y, the pattern select and the pulse position. The top-level block registers its output together with `de/hs/vs`.

## Test plan

- Horizontal ramp, W=4, H=2, de_gap=0, hblank=3, vblank=5:
  - Required: `de` runs of 4 with `do_o` = 0,1,2,3 on each line; `hs` high for 3 cycles between the lines.
  - Required: `hs` and `vs` both high for 5 cycles at the end of the frame; exactly one `frame_done_o` pulse; total frame length 16 cycles.
- de_gap=1, W=25, H=25, delta pulse at (5,5):
  - Required: `de` alternates 0/1 within each line.
  - Required: exactly one `do_o`=255 in the frame, at pixel 5 of line 5.
  - Required: a monitor-captured BMP is identical to the `_25_25_8bit_deltapulse` bench input image.
- `en_i` dropped at pixel 2 of line 0:
  - Required: the frame completes normally, then the block goes to IDLE (`hs=vs=1`, `busy=0`).
  - Required: no second frame is generated.
- Configuration change mid-frame (width 4→8):
  - Required: the current frame keeps W=4.
  - Required: the next frame, started back-to-back, uses W=8.
- Reset held low for one cycle mid-line:
  - Required: the next edge shows `de=0`, `hs=1`, `vs=1`, `busy=0`.
  - Required: with `en_i` high, the following frame restarts at x=0, y=0.
- `width_i=0`, or `width_i=5000` with `LINE_SIZE_MAX=4096`:
  - Required for width 0: the block stays in IDLE.
  - Required for width 5000: lines carry 4096 pixels.

Source files
------------

// File: rtl/video_gen_pkg.sv
// Shared types for the video stream generator: FSM state encoding and
// test-pattern select codes.
package video_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_PIX,
    ST_HBLANK,
    ST_VBLANK
  } state_t;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_DELTA = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

endpackage

// File: rtl/video_stream_gen_if.sv
// di/de/hs/vs pixel stream bundle.
//   do_o : pixel data, valid while de_o is high
//   de_o : pixel valid
//   hs_o : high during line blanking and idle
//   vs_o : high during frame blanking and idle
interface video_stream_gen_if #(
  parameter int unsigned PIXEL_WIDTH = 8
);
  logic [PIXEL_WIDTH-1:0] do_o;
  logic                   de_o;
  logic                   hs_o;
  logic                   vs_o;

  modport master (output do_o, de_o, hs_o, vs_o);
  modport slave  (input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern pixel value for coordinate (x, y).
//   x, y             : current pixel position
//   pattern          : pattern select (PAT_* codes)
//   pulse_x, pulse_y : delta pulse position
//   pix_c            : pixel value
module video_pattern_gen
  import video_gen_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned XW          = 13,
  parameter int unsigned YW          = 12
) (
  input  logic [XW-1:0]          x,
  input  logic [YW-1:0]          y,
  input  logic [1:0]             pattern,
  input  logic [15:0]            pulse_x,
  input  logic [15:0]            pulse_y,
  output logic [PIXEL_WIDTH-1:0] pix_c
);

  always_comb begin
    pix_c = '0;
    case (pattern)
      PAT_HRAMP: pix_c = PIXEL_WIDTH'(x);
      PAT_VRAMP: pix_c = PIXEL_WIDTH'(y);
      // A pulse outside the frame never matches, giving an all-zero frame.
      PAT_DELTA: if ((16'(x) == pulse_x) && (16'(y) == pulse_y)) pix_c = '1;
      PAT_CHECK: if (x[3] ^ y[3]) pix_c = '1;
      default:   pix_c = '0;
    endcase
  end

endmodule

// File: rtl/video_stream_gen.sv
// Test-pattern video source on the di/de/hs/vs stream protocol.
//   clk, rst       : clock, synchronous active-low reset
//   en_i           : run; frames are produced back-to-back while high
//   width_i        : pixels per line (clamped to LINE_SIZE_MAX)
//   height_i       : lines per frame (clamped to FRAME_SIZE_MAX)
//   de_gap_i       : de=0 cycles before each pixel
//   hblank_i       : line blanking cycles (minimum 1)
//   vblank_i       : frame blanking cycles (minimum 1)
//   pattern_i      : pattern select
//   pulse_x_i/y_i  : delta pulse position
//   vid            : registered pixel stream (master)
//   busy_o         : frame in progress
//   frame_done_o   : pulse on the final frame blanking cycle
module video_stream_gen
  import video_gen_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH    = 8,
  parameter int unsigned LINE_SIZE_MAX  = 4096,
  parameter int unsigned FRAME_SIZE_MAX = 2048,
  parameter int unsigned BLANK_WIDTH    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en_i,
  input  logic [$clog2(LINE_SIZE_MAX+1)-1:0]     width_i,
  input  logic [$clog2(FRAME_SIZE_MAX+1)-1:0]    height_i,
  input  logic [3:0]                             de_gap_i,
  input  logic [BLANK_WIDTH-1:0]                 hblank_i,
  input  logic [BLANK_WIDTH-1:0]                 vblank_i,
  input  logic [1:0]                             pattern_i,
  input  logic [15:0]                            pulse_x_i,
  input  logic [15:0]                            pulse_y_i,
  video_stream_gen_if.master                     vid,
  output logic                                   busy_o,
  output logic                                   frame_done_o
);

  localparam int unsigned XW = $clog2(LINE_SIZE_MAX + 1);
  localparam int unsigned YW = $clog2(FRAME_SIZE_MAX + 1);

  state_t                 state, state_nxt;
  logic [XW-1:0]          x, x_nxt;
  logic [YW-1:0]          y, y_nxt;
  logic [BLANK_WIDTH-1:0] cnt, cnt_nxt;

  logic [XW-1:0]          w_cfg;
  logic [YW-1:0]          h_cfg;
  logic [3:0]             gap_cfg;
  logic [BLANK_WIDTH-1:0] hb_cfg, vb_cfg;
  logic [1:0]             pat_cfg;
  logic [15:0]            px_cfg, py_cfg;

  logic                   load_c;
  logic                   frame_last_c;
  logic                   start_ok_c;
  logic [XW-1:0]          width_clamp_c;
  logic [YW-1:0]          height_clamp_c;
  state_t                 first_st_c;
  state_t                 line_st_c;
  logic                   x_last_c, y_last_c;
  logic [BLANK_WIDTH-1:0] gap_end_c, hb_end_c, vb_end_c;
  logic [PIXEL_WIDTH-1:0] pix_c;

  // Input-side configuration conditioning.
  always_comb begin
    width_clamp_c  = (width_i > XW'(LINE_SIZE_MAX)) ? XW'(LINE_SIZE_MAX) : width_i;
    height_clamp_c = (height_i > YW'(FRAME_SIZE_MAX)) ? YW'(FRAME_SIZE_MAX) : height_i;
    start_ok_c     = en_i && (width_i != '0) && (height_i != '0);
    first_st_c     = (de_gap_i == 4'd0) ? ST_PIX : ST_GAP;
  end

  // Terminal-count values; zero blanking is stretched to one cycle.
  always_comb begin
    line_st_c = (gap_cfg == 4'd0) ? ST_PIX : ST_GAP;
    x_last_c  = (x == (w_cfg - XW'(1)));
    y_last_c  = (y == (h_cfg - YW'(1)));
    gap_end_c = BLANK_WIDTH'(gap_cfg) - BLANK_WIDTH'(1);
    hb_end_c  = (hb_cfg == '0) ? '0 : hb_cfg - BLANK_WIDTH'(1);
    vb_end_c  = (vb_cfg == '0) ? '0 : vb_cfg - BLANK_WIDTH'(1);
  end

  // State register and position counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt    = state;
    x_nxt        = x;
    y_nxt        = y;
    cnt_nxt      = cnt;
    load_c       = 1'b0;
    frame_last_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok_c) begin
          load_c    = 1'b1;
          x_nxt     = '0;
          y_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = first_st_c;
        end
      end
      ST_GAP: begin
        if (cnt == gap_end_c) begin
          cnt_nxt   = '0;
          state_nxt = ST_PIX;
        end else begin
          cnt_nxt = cnt + BLANK_WIDTH'(1);
        end
      end
      ST_PIX: begin
        cnt_nxt = '0;
        if (!x_last_c) begin
          x_nxt     = x + XW'(1);
          state_nxt = line_st_c;
        end else if (!y_last_c) begin
          state_nxt = ST_HBLANK;
        end else begin
          state_nxt = ST_VBLANK;
        end
      end
      ST_HBLANK: begin
        if (cnt == hb_end_c) begin
          cnt_nxt   = '0;
          x_nxt     = '0;
          y_nxt     = y + YW'(1);
          state_nxt = line_st_c;
        end else begin
          cnt_nxt = cnt + BLANK_WIDTH'(1);
        end
      end
      ST_VBLANK: begin
        if (cnt == vb_end_c) begin
          frame_last_c = 1'b1;
          cnt_nxt      = '0;
          x_nxt        = '0;
          y_nxt        = '0;
          if (start_ok_c) begin
            load_c    = 1'b1;
            state_nxt = first_st_c;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + BLANK_WIDTH'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Configuration is captured only at frame starts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_cfg   <= '0;
      h_cfg   <= '0;
      gap_cfg <= '0;
      hb_cfg  <= '0;
      vb_cfg  <= '0;
      pat_cfg <= PAT_HRAMP;
      px_cfg  <= '0;
      py_cfg  <= '0;
    end else if (load_c) begin
      w_cfg   <= width_clamp_c;
      h_cfg   <= height_clamp_c;
      gap_cfg <= de_gap_i;
      hb_cfg  <= hblank_i;
      vb_cfg  <= vblank_i;
      pat_cfg <= pattern_i;
      px_cfg  <= pulse_x_i;
      py_cfg  <= pulse_y_i;
    end
  end

  video_pattern_gen #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .XW          (XW),
    .YW          (YW)
  ) u_pattern (
    .x       (x),
    .y       (y),
    .pattern (pat_cfg),
    .pulse_x (px_cfg),
    .pulse_y (py_cfg),
    .pix_c   (pix_c)
  );

  // Output register: stream signals lag the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vid.do_o     <= '0;
      vid.de_o     <= 1'b0;
      vid.hs_o     <= 1'b1;
      vid.vs_o     <= 1'b1;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      vid.do_o     <= (state == ST_PIX) ? pix_c : '0;
      vid.de_o     <= (state == ST_PIX);
      vid.hs_o     <= (state == ST_IDLE) || (state == ST_HBLANK) || (state == ST_VBLANK);
      vid.vs_o     <= (state == ST_IDLE) || (state == ST_VBLANK);
      busy_o       <= (state != ST_IDLE);
      frame_done_o <= frame_last_c;
    end
  end

endmodule
